// File: rtl/io_display_pkg.sv
// Shared constants for the seven-segment display register bank: default addresses,
// access size codes, CTRL bit positions and the alignment rule.
package io_display_pkg;

  localparam logic [31:0] DEF_DATA_ADDR = 32'hFFFF_FC60;
  localparam logic [31:0] DEF_CTRL_ADDR = 32'hFFFF_FC64;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned CTRL_CLEAR = 0;
  localparam int unsigned CTRL_BLINK = 1;
  localparam int unsigned CTRL_ERR   = 7;

  // CTRL only accepts aligned words; DATA accepts naturally aligned byte/half/word.
  function automatic logic misaligned(logic is_ctrl, logic [1:0] size, logic [1:0] off);
    logic bad;
    bad = 1'b0;
    unique case (size)
      SZ_BYTE: bad = is_ctrl;
      SZ_HALF: bad = is_ctrl | off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/io_display_reg_if.sv
// CPU-side load/store bus into the display register bank.
interface io_display_reg_if;
  logic        io_write;
  logic        io_read;
  logic [31:0] addr;
  logic [1:0]  size;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output io_write, io_read, addr, size, wdata,
    input  rdata, ack
  );

  modport slave (
    input  io_write, io_read, addr, size, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/blink_timer.sv
// Free-running half-period divider for display blinking; phase toggles every BLINK_DIV
// cycles while en is high. Built only when IO_DISPLAY_BLINK_EN is defined.
module blink_timer #(
  parameter int unsigned BLINK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase
);

  localparam int unsigned CntW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CntW'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/io_display_reg.sv
// Memory-mapped display data/control registers feeding the seven-segment driver.
// Hardware blinking is built only when IO_DISPLAY_BLINK_EN is defined.
module io_display_reg
  import io_display_pkg::*;
#(
  parameter logic [31:0] DATA_ADDR = DEF_DATA_ADDR,
  parameter logic [31:0] CTRL_ADDR = DEF_CTRL_ADDR,
  parameter int unsigned BLINK_DIV = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  io_display_reg_if.slave         bus,
  output logic             [31:0] digital,
  output logic                    disp_valid
);

  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        blink_en_q;

  logic        hit, is_ctrl, access, wr, rd, bad;
  logic [31:0] ctrl_rd;

`ifdef IO_DISPLAY_BLINK_EN
  logic blink_en_d;
  logic blink_phase;

  // Gating with the next value lets a write of blink_en=0 reset the timer on that edge.
  blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (blink_en_q & blink_en_d),
    .phase (blink_phase)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) blink_en_q <= 1'b0;
    else      blink_en_q <= blink_en_d;
  end

  assign digital = blink_phase ? '0 : data_q;
`else
  assign blink_en_q = 1'b0;
  assign digital    = data_q;
`endif

  assign hit     = (bus.addr[31:3] == DATA_ADDR[31:3]);
  assign is_ctrl = (bus.addr[31:2] == CTRL_ADDR[31:2]);
  assign access  = hit & (bus.io_write | bus.io_read);
  assign wr      = hit & bus.io_write;
  assign rd      = hit & bus.io_read & ~bus.io_write;
  assign bad     = misaligned(is_ctrl, bus.size, bus.addr[1:0]);

  always_comb begin
    ctrl_rd             = '0;
    ctrl_rd[CTRL_ERR]   = err_q;
    ctrl_rd[CTRL_BLINK] = blink_en_q;
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    ack_d   = access;
    rdata_d = '0;
`ifdef IO_DISPLAY_BLINK_EN
    blink_en_d = blink_en_q;
`endif
    if (access && bad) begin
      err_d = 1'b1;
    end else if (wr && !is_ctrl) begin
      valid_d = 1'b1;
      unique case (bus.size)
        SZ_BYTE: data_d[{bus.addr[1:0], 3'b000} +: 8] = bus.wdata[7:0];
        SZ_HALF: data_d[{bus.addr[1], 4'b0000} +: 16] = bus.wdata[15:0];
        default: data_d = bus.wdata;
      endcase
    end else if (wr) begin
      if (bus.wdata[CTRL_CLEAR]) begin
        data_d  = '0;
        valid_d = 1'b0;
        err_d   = 1'b0;
      end
`ifdef IO_DISPLAY_BLINK_EN
      blink_en_d = bus.wdata[CTRL_BLINK];
`endif
    end else if (rd) begin
      rdata_d = is_ctrl ? ctrl_rd : data_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.rdata   = rdata_q;
  assign disp_valid  = valid_q;

endmodule

// File: tb/tb_io_display_reg.sv
// Self-checking bench for io_display_reg: directed scenarios plus a randomized access
// stream checked against a byte-lane reference model.
module tb_io_display_reg;
  import io_display_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] digital;
  logic        disp_valid;

  always #5 clk = ~clk;

  io_display_reg_if bus ();

  io_display_reg #(
    .BLINK_DIV (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .digital    (digital),
    .disp_valid (disp_valid)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  m_bytes [4];
  bit          m_valid, m_err, m_blink;
  logic        exp_ack;
  logic [31:0] exp_rdata;

  function logic [31:0] m_word();
    return {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
  endfunction

  task model_reset();
    for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;
    m_valid   = 0;
    m_err     = 0;
    m_blink   = 0;
    exp_ack   = 0;
    exp_rdata = 0;
  endtask

  task model_access(input bit wr, input bit rd, input logic [31:0] a, input logic [1:0] sz,
                    input logic [31:0] wd);
    bit hit, isc, good;
    int off;
    hit       = (a >= 32'hFFFF_FC60) && (a <= 32'hFFFF_FC67);
    exp_ack   = hit && (wr || rd);
    exp_rdata = 0;
    if (!exp_ack) return;
    off  = int'(a[1:0]);
    isc  = (a >= 32'hFFFF_FC64);
    if (sz == 3)      good = 0;
    else if (isc)     good = (sz == 2) && (off == 0);
    else if (sz == 0) good = 1;
    else if (sz == 1) good = (off % 2 == 0);
    else              good = (off == 0);
    if (!good) begin
      m_err = 1;
    end else if (wr && !isc) begin
      m_valid = 1;
      if (sz == 0) m_bytes[off] = wd[7:0];
      else if (sz == 1) begin
        m_bytes[off]     = wd[7:0];
        m_bytes[off + 1] = wd[15:8];
      end else begin
        for (int i = 0; i < 4; i++) m_bytes[i] = wd[8*i +: 8];
      end
    end else if (wr) begin
      if (wd[0]) begin
        for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;
        m_valid = 0;
        m_err   = 0;
      end
`ifdef IO_DISPLAY_BLINK_EN
      m_blink = wd[1];
`endif
    end else begin
      exp_rdata = isc ? (32'(m_err) * 32'h80 + 32'(m_blink) * 32'h2) : m_word();
    end
  endtask

  // Drives one access for one edge (called at a negedge), returns at the next negedge.
  task access(input bit wr, input bit rd, input logic [31:0] a, input logic [1:0] sz,
              input logic [31:0] wd);
    bus.io_write = wr;
    bus.io_read  = rd;
    bus.addr     = a;
    bus.size     = sz;
    bus.wdata    = wd;
    model_access(wr, rd, a, sz, wd);
    @(posedge clk);
    #1;
    bus.io_write = 0;
    bus.io_read  = 0;
    @(negedge clk);
  endtask

  task test_reset();
    rst          = 0;
    bus.io_write = 0;
    bus.io_read  = 0;
    bus.addr     = 0;
    bus.size     = 0;
    bus.wdata    = 0;
    model_reset();
    #1;
    checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus.ack); end
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
    checks++; if (digital !== 32'h0) begin failures++; $display("FAIL reset_digital got=%h exp=0", digital); end
    checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", disp_valid); end
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask

  task test_word_write();
    access(1, 0, 32'hFFFF_FC60, SZ_WORD, 32'h1234_5678);
    checks++; if (digital !== 32'h1234_5678) begin failures++; $display("FAIL word_digital got=%h exp=12345678", digital); end
    checks++; if (disp_valid !== 1'b1) begin failures++; $display("FAIL word_valid got=%b exp=1", disp_valid); end
    checks++; if (bus.ack !== 1'b1) begin failures++; $display("FAIL word_ack got=%b exp=1", bus.ack); end
    @(negedge clk);
    checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL word_ack_pulse got=%b exp=0", bus.ack); end
  endtask

  task test_byte_half();
    access(1, 0, 32'hFFFF_FC62, SZ_BYTE, 32'h0000_00AB);
    checks++; if (digital !== 32'h12AB_5678) begin failures++; $display("FAIL byte_digital got=%h exp=12ab5678", digital); end
    access(1, 0, 32'hFFFF_FC60, SZ_HALF, 32'h0000_CDEF);
    checks++; if (digital !== 32'h12AB_CDEF) begin failures++; $display("FAIL half_digital got=%h exp=12abcdef", digital); end
    access(0, 1, 32'hFFFF_FC60, SZ_WORD, 32'h0);
    checks++; if (bus.ack !== 1'b1) begin failures++; $display("FAIL data_read_ack got=%b exp=1", bus.ack); end
    checks++; if (bus.rdata !== 32'h12AB_CDEF) begin failures++; $display("FAIL data_read got=%h exp=12abcdef", bus.rdata); end
  endtask

  task test_misaligned_clear();
    access(1, 0, 32'hFFFF_FC61, SZ_WORD, 32'hDEAD_BEEF);
    checks++; if (bus.ack !== 1'b1) begin failures++; $display("FAIL misal_ack got=%b exp=1", bus.ack); end
    checks++; if (digital !== 32'h12AB_CDEF) begin failures++; $display("FAIL misal_digital got=%h exp=12abcdef", digital); end
    access(0, 1, 32'hFFFF_FC64, SZ_WORD, 32'h0);
    checks++; if (bus.rdata !== 32'h0000_0080) begin failures++; $display("FAIL ctrl_err_read got=%h exp=80", bus.rdata); end
    access(1, 0, 32'hFFFF_FC64, SZ_WORD, 32'h1);
    checks++; if (digital !== 32'h0) begin failures++; $display("FAIL clear_digital got=%h exp=0", digital); end
    checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL clear_valid got=%b exp=0", disp_valid); end
    access(0, 1, 32'hFFFF_FC64, SZ_WORD, 32'h0);
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL ctrl_clear_read got=%h exp=0", bus.rdata); end
  endtask

  task test_collision_miss();
    access(1, 1, 32'hFFFF_FC60, SZ_WORD, 32'h0000_00FF);
    checks++; if (digital !== 32'hFF) begin failures++; $display("FAIL rw_digital got=%h exp=ff", digital); end
    checks++; if (bus.ack !== 1'b1) begin failures++; $display("FAIL rw_ack got=%b exp=1", bus.ack); end
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL rw_rdata got=%h exp=0", bus.rdata); end
    @(negedge clk);
    checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL rw_single_ack got=%b exp=0", bus.ack); end
    access(1, 0, 32'hFFFF_FC68, SZ_WORD, 32'h7777_7777);
    checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL miss_ack got=%b exp=0", bus.ack); end
    checks++; if (digital !== 32'hFF) begin failures++; $display("FAIL miss_digital got=%h exp=ff", digital); end
  endtask

  task test_blink();
    logic [31:0] exp;
    access(1, 0, 32'hFFFF_FC60, SZ_WORD, 32'h55);
    access(1, 0, 32'hFFFF_FC64, SZ_WORD, 32'h2);
`ifdef IO_DISPLAY_BLINK_EN
    for (int k = 0; k < 12; k++) begin
      exp = ((k / 4) % 2 == 1) ? 32'h0 : 32'h55;
      checks++;
      if (digital !== exp) begin failures++; $display("FAIL blink_k%0d got=%h exp=%h", k, digital, exp); end
      if (k < 11) @(negedge clk);
    end
    access(0, 1, 32'hFFFF_FC64, SZ_WORD, 32'h0);
    checks++; if (bus.rdata !== 32'h2) begin failures++; $display("FAIL blink_read got=%h exp=2", bus.rdata); end
`else
    access(0, 1, 32'hFFFF_FC64, SZ_WORD, 32'h0);
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL blink_tied got=%h exp=0", bus.rdata); end
`endif
    access(1, 0, 32'hFFFF_FC64, SZ_WORD, 32'h0);
    repeat (6) begin
      checks++; if (digital !== 32'h55) begin failures++; $display("FAIL blink_off got=%h exp=55", digital); end
      @(negedge clk);
    end
  endtask

  task test_random();
    logic [31:0] a, wd;
    logic [1:0]  sz;
    bit          wr, rd;
    int          r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'hFFFF_FC68 + 32'($urandom_range(0, 7));
      else             a = 32'hFFFF_FC60 + 32'($urandom_range(0, 7));
      sz = 2'($urandom_range(0, 3));
      wr = ($urandom_range(0, 1) == 1);
      rd = ($urandom_range(0, 1) == 1);
      wd = $urandom;
      if (a[2]) begin
        wd[1] = 1'b0;
        wd[0] = ($urandom_range(0, 7) == 0);
      end
      access(wr, rd, a, sz, wd);
      checks++; if (bus.ack !== exp_ack) begin failures++; $display("FAIL rnd_ack n=%0d got=%b exp=%b", n, bus.ack, exp_ack); end
      checks++; if (bus.rdata !== exp_rdata) begin failures++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, bus.rdata, exp_rdata); end
      checks++; if (digital !== m_word()) begin failures++; $display("FAIL rnd_digital n=%0d got=%h exp=%h", n, digital, m_word()); end
      checks++; if (disp_valid !== m_valid) begin failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, disp_valid, m_valid); end
    end
  endtask

  task test_reset_mid();
    access(1, 0, 32'hFFFF_FC60, SZ_WORD, 32'hA5A5_A5A5);
    bus.io_write = 1;
    bus.addr     = 32'hFFFF_FC60;
    bus.size     = SZ_WORD;
    bus.wdata    = 32'h3C3C_3C3C;
    @(posedge clk);
    #1;
    bus.io_write = 0;
    #1;
    rst = 0;
    model_reset();
    #1;
    checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL midrst_ack got=%b exp=0", bus.ack); end
    checks++; if (digital !== 32'h0) begin failures++; $display("FAIL midrst_digital got=%h exp=0", digital); end
    checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", disp_valid); end
    @(negedge clk);
    rst = 1;
    repeat (2) begin
      @(negedge clk);
      checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL midrst_noack got=%b exp=0", bus.ack); end
    end
    checks++; if (digital !== 32'h0) begin failures++; $display("FAIL midrst_after got=%h exp=0", digital); end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_byte_half();
    test_misaligned_clear();
    test_collision_miss();
    test_blink();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
